// File: rtl/eth_pkg.sv
// eth_pkg: shared width and FSM state types for the Ethernet RX frame FIFO.
package eth_pkg;
   localparam int AXIS_DATA_W = 32;
   typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DROP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_READ} rd_state_t;
endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if: AXI-Stream beat bundle with master/slave views.
interface eth_rx_frame_fifo_if;
   import eth_pkg::*;
   logic [AXIS_DATA_W-1:0] tdata;
   logic tvalid;
   logic tlast;
   logic tuser;
   logic tready;
   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_desc_fifo.sv
// eth_desc_fifo: synchronous FIFO holding committed-frame length descriptors.
module eth_desc_fifo #(
   parameter int DEPTH = 16,
   parameter int W = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty = wp == rp;
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full) wp <= wp + 1'b1;
         if (pop && !empty) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !full) mem[wp[AW-1:0]] <= din;
   end
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame buffer; bad or unfit frames are
// discarded by rewinding the write pointer, committed frames replay on m_axis.
module eth_rx_frame_fifo import eth_pkg::*; #(
   parameter int DEPTH = 256,
   parameter int FRAME_DEPTH = 16
) (
   input  logic aclk,
   input  logic aresetn,
   eth_rx_frame_fifo_if.slave s_axis,
   eth_rx_frame_fifo_if.master m_axis,
   output logic frame_drop,
   output logic [$clog2(FRAME_DEPTH):0] frame_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FRAME_DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] TWO = (AW+1)'(2);
   logic [AXIS_DATA_W-1:0] mem [DEPTH];
   logic [AXIS_DATA_W-1:0] tdata_q;
   logic [AW:0] wr_ptr, wr_start, rd_ptr, rd_nxt, rem, desc_in, desc_len;
   logic ready, full, room, desc_full, desc_empty, beat, push, pop, wr_en, rewind;
   logic tvalid_q, tlast_q, hs, last_hs;
   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   assign full = (wr_ptr - rd_ptr) == {1'b1, {AW{1'b0}}};
   // Outstanding frames (queued plus the one being replayed) are capped at FRAME_DEPTH
   assign room = !desc_full && frame_count != {1'b1, {FW{1'b0}}};
   assign beat = s_axis.tvalid && ready;
   assign hs = tvalid_q && m_axis.tready;
   assign last_hs = hs && tlast_q;
   assign rd_nxt = rd_ptr + {{AW{1'b0}}, hs};
   assign desc_in = wr_ptr - wr_start + 1'b1;
   assign s_axis.tready = ready;
   assign m_axis.tdata = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast = tlast_q;
   assign m_axis.tuser = 1'b0;
   eth_desc_fifo #(.DEPTH(FRAME_DEPTH), .W(AW+1)) u_desc (
      .clk(aclk), .rst_n(aresetn), .push(push), .pop(pop), .din(desc_in),
      .dout(desc_len), .full(desc_full), .empty(desc_empty)
   );
   always_comb begin
      wr_next = wr_state;
      wr_en = 1'b0;
      push = 1'b0;
      rewind = 1'b0;
      if (beat) begin
         if (wr_state == WR_DROP || full) begin
            rewind = s_axis.tlast;
            wr_next = s_axis.tlast ? WR_IDLE : WR_DROP;
         end else begin
            wr_en = 1'b1;
            push = s_axis.tlast && !s_axis.tuser && room;
            rewind = s_axis.tlast && !push;
            wr_next = s_axis.tlast ? WR_IDLE : WR_WRITE;
         end
      end
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state <= WR_IDLE;
         wr_ptr <= '0;
         wr_start <= '0;
         frame_drop <= 1'b0;
         ready <= 1'b0;
      end else begin
         wr_state <= wr_next;
         ready <= 1'b1;
         frame_drop <= rewind;
         if (rewind) wr_ptr <= wr_start;
         else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (push) wr_start <= wr_ptr + 1'b1;
      end
   end
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= s_axis.tdata;
   end
   // A finished frame hands straight over to the next descriptor without a bubble
   always_comb begin
      rd_next = rd_state;
      pop = 1'b0;
      if (rd_state == RD_IDLE || last_hs) begin
         pop = !desc_empty;
         rd_next = desc_empty ? RD_IDLE : RD_READ;
      end
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state <= RD_IDLE;
         rd_ptr <= '0;
         rem <= '0;
         tdata_q <= '0;
         tvalid_q <= 1'b0;
         tlast_q <= 1'b0;
         frame_count <= '0;
      end else begin
         rd_state <= rd_next;
         rd_ptr <= rd_nxt;
         if (pop) begin
            rem <= desc_len;
            tlast_q <= desc_len == ONE;
            tdata_q <= mem[rd_nxt[AW-1:0]];
            tvalid_q <= 1'b1;
         end else if (hs && !tlast_q) begin
            rem <= rem - ONE;
            tlast_q <= rem == TWO;
            tdata_q <= mem[rd_nxt[AW-1:0]];
         end else if (hs) begin
            tvalid_q <= 1'b0;
         end
         if (push && !last_hs) frame_count <= frame_count + 1'b1;
         else if (!push && last_hs) frame_count <= frame_count - 1'b1;
      end
   end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: directed and randomized frames checked against a queue model.
module tb_eth_rx_frame_fifo;
   localparam int DEPTH = 256;
   localparam int FDEPTH = 16;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic frame_drop;
   logic [4:0] frame_count;
   eth_rx_frame_fifo_if s_if ();
   eth_rx_frame_fifo_if m_if ();
   eth_rx_frame_fifo #(.DEPTH(DEPTH), .FRAME_DEPTH(FDEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
      .frame_drop(frame_drop), .frame_count(frame_count)
   );
   always #5 aclk = ~aclk;

   int total = 0;
   int bad = 0;
   int drops = 0;
   int exp_drops = 0;
   int outstanding = 0;
   int occupied = 0;
   int rmode = 1;
   logic [32:0] expq[$];
   logic [31:0] frame[$];
   logic stall = 1'b0;
   logic [31:0] st_data;
   logic st_last;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Consumer ready pattern: 0 stall, 1 always ready, 2 toggle, 3 random
   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         case (rmode)
            0: m_if.tready = 1'b0;
            1: m_if.tready = 1'b1;
            2: m_if.tready = !m_if.tready;
            default: m_if.tready = 1'($urandom_range(1));
         endcase
      end
   end

   always @(negedge aclk) begin
      if (!aresetn) stall = 1'b0;
      else begin
         if (frame_drop) drops++;
         if (stall) begin
            check("stall_valid", m_if.tvalid, 1);
            check("stall_data", m_if.tdata, st_data);
            check("stall_last", m_if.tlast, st_last);
         end
         if (m_if.tvalid && m_if.tready) begin
            check("beat_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
               check("out_data", m_if.tdata, expq[0][31:0]);
               check("out_last", m_if.tlast, expq[0][32]);
               if (expq[0][32]) outstanding--;
               occupied--;
               void'(expq.pop_front());
            end
         end
         stall = m_if.tvalid && !m_if.tready;
         st_data = m_if.tdata;
         st_last = m_if.tlast;
      end
   end

   task automatic beat(input logic [31:0] d, input logic l, input logic u);
      s_if.tvalid = 1'b1;
      s_if.tdata = d;
      s_if.tlast = l;
      s_if.tuser = u;
      @(posedge aclk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      s_if.tuser = 1'b0;
   endtask

   // tuser is noise on non-final beats; only the final beat's flag decides the frame
   task automatic send_frame(input logic u);
      int n = frame.size();
      for (int i = 0; i < n; i++)
         beat(frame[i], i == n - 1, (i == n - 1) ? u : 1'($urandom_range(1)));
      if (!u && n <= DEPTH - occupied && outstanding < FDEPTH) begin
         for (int i = 0; i < n; i++) expq.push_back({i == n - 1, frame[i]});
         occupied += n;
         outstanding++;
      end else exp_drops++;
   endtask

   task automatic rand_frame(input int n);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back($urandom);
   endtask

   task automatic drain(input string tag);
      rmode = 1;
      for (int i = 0; i < 3000 && expq.size() != 0; i++) tick(1);
      tick(3);
      check(tag, expq.size(), 0);
      check("count_after_drain", frame_count, outstanding);
      check("drops_after_drain", drops, exp_drops);
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata = '0;
      s_if.tlast = 1'b0;
      s_if.tuser = 1'b0;
      tick(2);
      check("rst_s_ready", s_if.tready, 0);
      check("rst_m_valid", m_if.tvalid, 0);
      check("rst_m_data", m_if.tdata, 0);
      check("rst_m_last", m_if.tlast, 0);
      check("rst_drop", frame_drop, 0);
      check("rst_count", frame_count, 0);
      aresetn = 1'b1;
      #1;
      check("ready_after_release", s_if.tready, 0);
      tick(1);
      check("ready_first_clock", s_if.tready, 1);

      // good 4-word frame and first-word latency
      frame = '{32'h11, 32'h22, 32'h33, 32'h44};
      send_frame(1'b0);
      check("lat_n1_valid", m_if.tvalid, 0);
      tick(1);
      check("lat_n2_valid", m_if.tvalid, 1);
      check("lat_n2_data", m_if.tdata, 32'h11);
      drain("good4_drain");

      // errored frame followed by a short good frame
      rand_frame(5);
      send_frame(1'b1);
      frame = '{32'hA, 32'hB};
      send_frame(1'b0);
      drain("bad_then_good_drain");
      check("one_drop_total", drops, 1);

      // overflow drop, then a frame that fits while the consumer stalls
      rmode = 0;
      tick(1);
      rand_frame(300);
      send_frame(1'b0);
      rand_frame(10);
      send_frame(1'b0);
      tick(3);
      check("ovf_count", frame_count, 1);
      check("ovf_drops", drops, exp_drops);
      drain("ovf_drain");

      // exactly DEPTH words fits
      rmode = 0;
      tick(1);
      rand_frame(DEPTH);
      send_frame(1'b0);
      tick(3);
      check("full_depth_count", frame_count, 1);
      check("full_depth_drops", drops, exp_drops);
      drain("full_depth_drain");

      // consumer toggling ready every cycle
      rmode = 2;
      rand_frame(8);
      send_frame(1'b0);
      drain("toggle_drain");

      // descriptor exhaustion with single-word frames
      rmode = 0;
      tick(1);
      for (int f = 0; f < 17; f++) begin
         rand_frame(1);
         send_frame(1'b0);
      end
      tick(3);
      check("desc_full_count", frame_count, 16);
      check("desc_full_drops", drops, exp_drops);
      drain("desc_full_drain");

      // random frames, random errors, random consumer
      rmode = 3;
      for (int f = 0; f < 24; f++) begin
         for (int w = 0; w < 2000 && (occupied > 100 || outstanding > 8); w++) tick(1);
         rand_frame($urandom_range(16, 1));
         send_frame($urandom_range(4) == 0);
         tick($urandom_range(3));
      end
      drain("random_drain");

      // reset during an incoming frame and an ongoing readout
      rmode = 0;
      tick(1);
      rand_frame(12);
      send_frame(1'b0);
      tick(2);
      rmode = 1;
      for (int i = 0; i < 3; i++) beat($urandom, 1'b0, 1'b0);
      aresetn = 1'b0;
      #1;
      check("midrst_valid", m_if.tvalid, 0);
      check("midrst_count", frame_count, 0);
      check("midrst_ready", s_if.tready, 0);
      expq.delete();
      outstanding = 0;
      occupied = 0;
      tick(2);
      aresetn = 1'b1;
      tick(2);
      check("postrst_ready", s_if.tready, 1);
      rand_frame(3);
      send_frame(1'b0);
      drain("postrst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
